// File: rtl/demux_pkg.sv
// Shared constants, lane state type and helpers for the buffered 8-way demultiplexer.
package demux_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned OCC_W = 4;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    function automatic logic [OCC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux_lane_slot.sv
// One-entry output slot: holds a beat from load until drained; flush empties it
// but leaves the data register untouched.
module demux_lane_slot
    import demux_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic             flush_i,
    input  logic [width-1:0] data_i,
    output logic [width-1:0] data_o,
    output logic             valid_o
);

    lane_state_e      state_q, state_d;
    logic [width-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush_i) begin
            state_d = LANE_EMPTY;
        end else if (load_i) begin
            state_d = LANE_FULL;
            data_d  = data_i;
        end else if (drain_i && state_q == LANE_FULL) begin
            state_d = LANE_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == LANE_FULL);

endmodule

// File: rtl/demultiplexer_8way_buffered.sv
// Registered 1-to-8 distributor with one-entry slot per lane and a registered
// occupancy count.
module demultiplexer_8way_buffered
    import demux_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [width-1:0]       data_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   flush_i,
    output logic [LANES*width-1:0] data_o,
    output logic [LANES-1:0]       valid_o,
    input  logic [LANES-1:0]       ready_i,
    output logic [OCC_W-1:0]       occ_o
);

    logic             accept;
    logic [LANES-1:0] load_vec;
    logic [LANES-1:0] drain_vec;
    logic [OCC_W-1:0] occ_q, occ_d;

    // A full lane can still take a beat when its consumer empties it this cycle.
    assign ready_o   = rst_n & ~flush_i & (~valid_o[sel_i] | ready_i[sel_i]);
    assign accept    = valid_i & ready_o;
    assign drain_vec = valid_o & ready_i;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign load_vec[k] = accept & (sel_i == SEL_W'(k));

        demux_lane_slot #(
            .width(width)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_n  (rst_n),
            .load_i (load_vec[k]),
            .drain_i(drain_vec[k]),
            .flush_i(flush_i),
            .data_i (data_i),
            .data_o (data_o[k*width +: width]),
            .valid_o(valid_o[k])
        );
    end

    // Accepting into a full lane implies it drains, so the +1/-1 cancel there.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q - popcount(drain_vec) + OCC_W'(accept);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_o = occ_q;

endmodule

// File: tb/tb_demultiplexer_8way_buffered.sv
// Randomized self-checking bench for demultiplexer_8way_buffered against a
// per-lane array model.
module tb_demultiplexer_8way_buffered;

    localparam int W = 32;

    logic           clk_i = 1'b0;
    logic           rst_n;
    logic [W-1:0]   data_i;
    logic [2:0]     sel_i;
    logic           valid_i;
    logic           ready_o;
    logic           flush_i;
    logic [8*W-1:0] data_o;
    logic [7:0]     valid_o;
    logic [7:0]     ready_i;
    logic [3:0]     occ_o;

    int vectors = 0;
    int miscompares = 0;

    logic         mv[8];
    logic [W-1:0] md[8];

    demultiplexer_8way_buffered #(.width(W)) dut (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .data_i (data_i),
        .sel_i  (sel_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .flush_i(flush_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .occ_o  (occ_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] exp_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic logic [8*W-1:0] exp_data();
        logic [8*W-1:0] d;
        for (int k = 0; k < 8; k++) d[k*W +: W] = md[k];
        return d;
    endfunction

    function automatic logic [3:0] exp_occ();
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(mv[k]);
        return 4'(n);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
    endtask

    // Drive one cycle from a negedge; returns observed and model ready before the edge.
    task automatic cycle(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                         input logic [7:0] r, input logic f,
                         output logic obs_rdy, output logic exp_rdy);
        valid_i = v; sel_i = s; data_i = d; ready_i = r; flush_i = f;
        #1;
        obs_rdy = ready_o;
        exp_rdy = !f && (!mv[s] || r[s]);
        @(posedge clk_i);
        for (int k = 0; k < 8; k++) begin
            if (f) mv[k] = 1'b0;
            else if (v && exp_rdy && s == 3'(k)) begin
                mv[k] = 1'b1;
                md[k] = d;
            end else if (mv[k] && r[k]) mv[k] = 1'b0;
        end
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = '0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; sel_i = '0; data_i = '0; ready_i = '0; flush_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        vectors++;
        if (valid_o !== 8'h00) begin miscompares++; $display("FAIL reset_valid got=%h exp=00", valid_o); end
        vectors++;
        if (data_o !== '0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", data_o); end
        vectors++;
        if (occ_o !== 4'd0) begin miscompares++; $display("FAIL reset_occ got=%0d exp=0", occ_o); end
        vectors++;
        if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_fill();
        logic o, e;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 3'(k), 32'hA0 + 32'(k), 8'h00, 1'b0, o, e);
            vectors++;
            if (o !== 1'b1) begin miscompares++; $display("FAIL fill_ready lane=%0d got=%b exp=1", k, o); end
        end
        vectors++;
        if (valid_o !== 8'hFF) begin miscompares++; $display("FAIL fill_valid got=%h exp=ff", valid_o); end
        vectors++;
        if (occ_o !== 4'd8) begin miscompares++; $display("FAIL fill_occ got=%0d exp=8", occ_o); end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (data_o[k*W +: W] !== 32'hA0 + 32'(k)) begin
                miscompares++; $display("FAIL fill_data lane=%0d got=%h exp=%h", k, data_o[k*W +: W], 32'hA0 + 32'(k));
            end
        end
        cycle(1'b1, 3'd3, 32'h99, 8'h00, 1'b0, o, e);
        vectors++;
        if (o !== 1'b0) begin miscompares++; $display("FAIL ninth_ready got=%b exp=0", o); end
        vectors++;
        if (data_o[3*W +: W] !== 32'hA3) begin miscompares++; $display("FAIL ninth_hold got=%h exp=a3", data_o[3*W +: W]); end
    endtask

    task automatic test_async_reset();
        valid_i = 1'b1; sel_i = 3'd1; data_i = 32'h55;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (valid_o !== 8'h00 || occ_o !== 4'd0 || data_o !== '0) begin
            miscompares++; $display("FAIL async_reset got valid=%h occ=%0d exp 00/0", valid_o, occ_o);
        end
        vectors++;
        if (ready_o !== 1'b0) begin miscompares++; $display("FAIL async_reset_ready got=%b exp=0", ready_o); end
        model_reset();
        @(negedge clk_i);
        rst_n = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (valid_o !== 8'h00) begin miscompares++; $display("FAIL reset_discard got=%h exp=00", valid_o); end
    endtask

    task automatic test_passthrough();
        logic o, e;
        logic [3:0] occ_before;
        cycle(1'b1, 3'd5, 32'h11, 8'h00, 1'b0, o, e);
        cycle(1'b1, 3'd0, 32'h77, 8'h00, 1'b0, o, e);
        occ_before = occ_o;
        cycle(1'b1, 3'd5, 32'h22, 8'h20, 1'b0, o, e);
        vectors++;
        if (o !== 1'b1) begin miscompares++; $display("FAIL pass_ready got=%b exp=1", o); end
        vectors++;
        if (data_o[5*W +: W] !== 32'h22 || valid_o[5] !== 1'b1) begin
            miscompares++; $display("FAIL pass_data got=%h v=%b exp=22 v=1", data_o[5*W +: W], valid_o[5]);
        end
        vectors++;
        if (occ_o !== occ_before || occ_o !== exp_occ()) begin
            miscompares++; $display("FAIL pass_occ got=%0d exp=%0d", occ_o, exp_occ());
        end
    endtask

    task automatic test_drain();
        logic o, e;
        cycle(1'b0, 3'd0, '0, 8'hFF, 1'b0, o, e);
        cycle(1'b1, 3'd0, 32'h100, 8'h00, 1'b0, o, e);
        cycle(1'b1, 3'd2, 32'h102, 8'h00, 1'b0, o, e);
        cycle(1'b1, 3'd7, 32'h107, 8'h00, 1'b0, o, e);
        vectors++;
        if (valid_o !== 8'h85) begin miscompares++; $display("FAIL drain_pre got=%h exp=85", valid_o); end
        cycle(1'b0, 3'd0, '0, 8'h85, 1'b0, o, e);
        vectors++;
        if (valid_o !== 8'h00) begin miscompares++; $display("FAIL drain_valid got=%h exp=00", valid_o); end
        vectors++;
        if (occ_o !== 4'd0) begin miscompares++; $display("FAIL drain_occ got=%0d exp=0", occ_o); end
    endtask

    task automatic test_flush();
        logic o, e;
        logic [W-1:0] lane6_before;
        cycle(1'b1, 3'd1, 32'h201, 8'h00, 1'b0, o, e);
        cycle(1'b1, 3'd4, 32'h204, 8'h00, 1'b0, o, e);
        lane6_before = data_o[6*W +: W];
        cycle(1'b1, 3'd6, 32'hBAD6, 8'h00, 1'b1, o, e);
        vectors++;
        if (o !== 1'b0) begin miscompares++; $display("FAIL flush_ready got=%b exp=0", o); end
        vectors++;
        if (valid_o !== 8'h00 || occ_o !== 4'd0) begin
            miscompares++; $display("FAIL flush_state got valid=%h occ=%0d exp 00/0", valid_o, occ_o);
        end
        vectors++;
        if (data_o[6*W +: W] !== lane6_before) begin
            miscompares++; $display("FAIL flush_noload got=%h exp=%h", data_o[6*W +: W], lane6_before);
        end
    endtask

    task automatic test_backpressure();
        logic o, e;
        logic [2:0] s;
        cycle(1'b1, 3'd2, 32'hDEAD, 8'h00, 1'b0, o, e);
        for (int i = 0; i < 10; i++) begin
            s = 3'($urandom_range(0, 7));
            if (s == 3'd2) s = 3'd3;
            cycle(1'($urandom), s, $urandom, 8'($urandom) & 8'hFB, 1'b0, o, e);
            vectors++;
            if (data_o[2*W +: W] !== 32'hDEAD || valid_o[2] !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold cyc=%0d got=%h v=%b exp=dead v=1", i, data_o[2*W +: W], valid_o[2]);
            end
        end
        cycle(1'b0, 3'd0, '0, 8'h04, 1'b0, o, e);
        vectors++;
        if (valid_o[2] !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%b exp=0", valid_o[2]); end
    endtask

    task automatic test_random();
        logic o, e;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), 3'($urandom), $urandom, 8'($urandom),
                  ($urandom_range(0, 19) == 0), o, e);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, o, e); end
            vectors++;
            if (valid_o !== exp_valid() || occ_o !== exp_occ()) begin
                miscompares++; $display("FAIL rnd_state cyc=%0d got valid=%h occ=%0d exp valid=%h occ=%0d",
                                        i, valid_o, occ_o, exp_valid(), exp_occ());
            end
            vectors++;
            if (data_o !== exp_data()) begin
                miscompares++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, data_o, exp_data());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_async_reset();
        test_passthrough();
        test_drain();
        test_flush();
        test_backpressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
